// File: rtl/y_window.sv
// Vertical 5-tap binomial smoothing stage: four line buffers feed a three-stage
// multiply/add pipeline that emits one truncated 8-bit pixel per accepted input.
module y_window #(
  parameter int unsigned h0    = 6,
  parameter int unsigned h1    = 58,
  parameter int unsigned h2    = 128,
  parameter int unsigned WIDTH = 640
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       validin,
  input  logic       sof,
  output logic [7:0] dout,
  output logic       validout
);

  localparam int DATA_W = 8;
  localparam int PROD_W = 15;
  localparam int SUM_W  = 16;
  localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  logic [COL_W-1:0]    col;
  logic [COL_W-1:0]    cur_col;
  logic [2:0]          row;
  logic [2:0]          cur_row;
  logic                tag;
  logic                last_col;

  // One word per column packs rows {r-4, r-3, r-2, r-1}, newest row in the low byte.
  logic [4*DATA_W-1:0] lb [WIDTH];
  logic [4*DATA_W-1:0] lb_rd;

  logic [PROD_W-1:0]   prod0_p0, prod1_p0, prod2_p0, prod3_p0, prod4_p0;
  logic [SUM_W-1:0]    psum_a_p1, psum_b_p1;
  logic [PROD_W-1:0]   outer_p1;
  logic                vld_p0, vld_p1;

  function automatic logic [PROD_W-1:0] mul_coef(input int unsigned h,
                                                 input logic [DATA_W-1:0] x);
    return PROD_W'(h * x);
  endfunction

  function automatic logic [2:0] row_next(input logic [2:0] r);
    return (r >= 3'd4) ? 3'd4 : r + 3'd1;
  endfunction

  // Coefficients sum to 256, so dropping the low byte is the normalisation.
  function automatic logic [DATA_W-1:0] trunc_px(input logic [SUM_W-1:0] s);
    return s[SUM_W-1 -: DATA_W];
  endfunction

  // A pixel flagged as start of frame is column 0 of row 0 regardless of counters.
  always_comb begin
    cur_col  = sof ? '0 : col;
    cur_row  = sof ? '0 : row;
    last_col = (cur_col == LAST_COL);
    tag      = (cur_row >= 3'd4);
    lb_rd    = lb[cur_col];
  end

  // Stage boundary p0: line-buffer shift and tap products
  always_ff @(posedge clock) begin
    if (validin) begin
      lb[cur_col] <= {lb_rd[3*DATA_W-1:0], din};
      prod0_p0    <= mul_coef(h0, din);
      prod1_p0    <= mul_coef(h1, lb_rd[DATA_W-1:0]);
      prod2_p0    <= mul_coef(h2, lb_rd[2*DATA_W-1:DATA_W]);
      prod3_p0    <= mul_coef(h1, lb_rd[3*DATA_W-1:2*DATA_W]);
      prod4_p0    <= mul_coef(h0, lb_rd[4*DATA_W-1:3*DATA_W]);
    end
  end

  // Stage boundary p1: two partial sums plus the oldest-row outer product
  always_ff @(posedge clock) begin
    if (validin) begin
      psum_a_p1 <= {1'b0, prod0_p0} + {1'b0, prod1_p0};
      psum_b_p1 <= {1'b0, prod2_p0} + {1'b0, prod3_p0};
      outer_p1  <= prod4_p0;
    end
  end

  // Stage boundary p2: final sum into dout, counters and valid tags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      row      <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      validout <= 1'b0;
      dout     <= '0;
    end else begin
      validout <= 1'b0;
      if (validin) begin
        col      <= last_col ? '0 : cur_col + COL_W'(1);
        row      <= last_col ? row_next(cur_row) : cur_row;
        vld_p0   <= tag;
        vld_p1   <= vld_p0;
        validout <= vld_p1;
        dout     <= trunc_px(psum_a_p1 + psum_b_p1 + {1'b0, outer_p1});
      end
    end
  end

endmodule

// File: tb/tb_y_window.sv
// Directed bench for y_window (WIDTH=8): every accepted pixel carries a hand-derived
// expected result that is checked two acceptances later.
module tb_y_window;

  localparam int W = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = '0;
  logic       validin = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] dout;
  logic       validout;
  bit         clk_en = 1'b1;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  bit         last_known = 1'b0;
  logic [7:0] last_d = '0;
  logic [7:0] imp_tbl [5];

  y_window #(.h0(6), .h1(58), .h2(128), .WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .din     (din),
    .validin (validin),
    .sof     (sof),
    .dout    (dout),
    .validout(validout)
  );

  initial forever begin
    #5;
    if (clk_en) clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tagname, input logic [7:0] obs, input logic [7:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tagname, obs, expv);
    end
  endtask

  task automatic accept(input logic [7:0] pix, input logic s, input logic ev, input logic [7:0] ed);
    exp_t e;
    din     = pix;
    sof     = s;
    validin = 1'b1;
    @(posedge clock);
    #1;
    validin = 1'b0;
    sof     = 1'b0;
    q.push_back({ev, ed});
    if (q.size() > 2) begin
      e = q.pop_front();
      chk("validout", {7'd0, validout}, {7'd0, e.v});
      if (e.v) begin
        chk("dout", dout, e.d);
        last_known = 1'b1;
        last_d     = e.d;
      end else begin
        last_known = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      chk("idle_validout", {7'd0, validout}, 8'd0);
      if (last_known) chk("idle_dout_hold", dout, last_d);
    end
  endtask

  task automatic send_frame(input int rows, input logic [7:0] cval, input bit impulse,
                            input bit with_sof, input bit gaps);
    logic [7:0] pix, ed;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        if (impulse) begin
          pix = (r == 4 && c == 3) ? 8'd255 : 8'd0;
          ed  = (r >= 4 && c == 3) ? imp_tbl[r-4] : 8'd0;
        end else begin
          pix = cval;
          ed  = cval;
        end
        accept(pix, with_sof && r == 0 && c == 0, r >= 4, ed);
        if (gaps) idle($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    imp_tbl = '{8'd5, 8'd57, 8'd127, 8'd57, 8'd5};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_dout", dout, 8'd0);
    chk("reset_validout", {7'd0, validout}, 8'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Constant 100, six rows: first pulse after row 4 col 2
    send_frame(6, 8'd100, 1'b0, 1'b1, 1'b0);

    // Vertical impulse response in column 3
    send_frame(9, 8'd0, 1'b1, 1'b1, 1'b0);

    // Full-scale constant: sum 65280 without wrap
    send_frame(5, 8'd255, 1'b0, 1'b1, 1'b0);

    // Impulse again with random idle gaps
    send_frame(9, 8'd0, 1'b1, 1'b1, 1'b1);

    // sof at row 2 col 5 restarts counters
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (r < 2 || c < 5) accept(8'd50, r == 0 && c == 0, 1'b0, 8'd0);
    send_frame(5, 8'd50, 1'b0, 1'b1, 1'b0);

    // Reset mid row 5 with the clock stopped
    send_frame(5, 8'd80, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) accept(8'd80, 1'b0, 1'b1, 8'd80);
    clk_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_dout", dout, 8'd0);
    chk("async_reset_validout", {7'd0, validout}, 8'd0);
    q.delete();
    last_known = 1'b0;
    #10;
    reset  = 1'b1;
    clk_en = 1'b1;
    @(posedge clock);
    #1;
    send_frame(5, 8'd80, 1'b0, 1'b0, 1'b0);
    accept(8'd80, 1'b0, 1'b1, 8'd80);
    accept(8'd80, 1'b0, 1'b1, 8'd80);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/y_window.md
# y_window

Vertical 5-tap binomial smoothing stage that consumes the raster-ordered, horizontally filtered pixel stream produced by the horizontal window stage. Together the two stages form the separable 5x5 Gaussian pre-filter in front of feature detection. Four internal line buffers supply the five vertically aligned taps (rows r-4..r, same column), and the block emits one filtered 8-bit pixel per accepted input once four full lines have been buffered.

## Interface
- h0, 6: outer-tap coefficient (rows r and r-4)
- h1, 58: inner-tap coefficient (rows r-1 and r-3)
- h2, 128: centre-tap coefficient (row r-2); 2*h0 + 2*h1 + h2 must equal 256
- WIDTH, 640: pixels per line (line-buffer depth), ≥ 2
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- din  in  8  input pixel (horizontal-stage output)
- validin  in  1  din valid; the block advances only on cycles where this is high
- sof  in  1  start of frame, qualified by validin; marks the pixel at row 0, column 0
- dout  out  8  filtered pixel
- validout  out  1  dout holds a new valid result (one-cycle pulse per result)

## Operation
- An accepted pixel is any clock edge with validin=1. All counters, buffers and pipeline stages are enabled only by validin; idle cycles change nothing except clearing validout.
- Column counter col, 0..WIDTH-1, increments per accepted pixel and wraps WIDTH-1 → 0. Row counter row saturates at 4 and increments on each wrap.
- sof=1 with validin=1: that pixel is treated as col=0, row=0, and counters restart from it. sof without validin is ignored. Pixels already in the pipeline keep their valid tags and drain normally.
- Line buffers LB1..LB4 hold rows r-1..r-4 at each column. On acceptance at column c: taps = {din, LB1[c], LB2[c], LB3[c], LB4[c]}, then LB1[c]←din, LB2[c]←old LB1[c], LB3[c]←old LB2[c], LB4[c]←old LB3[c].
- sum = h0*din + h1*LB1[c] + h2*LB2[c] + h1*LB3[c] + h0*LB4[c]. Unsigned products are 15 bits; the sum is 16 bits and cannot overflow (max 255*256 = 65280). Result = sum[15:8] (truncate, no rounding).
- Valid tag per pixel = (row ≥ 4 after the sof/wrap update). The tag travels with the data through the pipeline.
- Pipeline: S1 registers taps and products; S2 registers two partial sums plus the h0 outer product; S3 registers the final sum, truncated into dout. There are no first-row or edge replicas: rows 0-3 produce no validout. Line-buffer contents are undefined after reset and only ever used once rows 0-3 have overwritten them.

## Timing
- Reset (reset=0, asynchronous): dout=0, validout=0, col=0, row=0, all pipeline tags cleared, immediately and without a clock edge. Line-buffer RAM is not cleared.
- Latency: the result for accepted pixel k is written into dout on the edge that accepts pixel k+2. validout=1 for exactly the following cycle iff that result's tag is set.
- The last two pixels of a frame flush only when further pixels are accepted, whether from the next frame or padding.
- Throughput: one pixel per clock sustained. Arbitrary validin gaps must not alter any result; dout holds its value through gaps.
- Reset released mid-frame: the next accepted pixel is treated as row 0, col 0 (an implicit sof).

## Test plan
- WIDTH=8, six rows of constant 100: 16 validout pulses (rows 4-5), each dout=100. The first pulse follows acceptance of row 4 col 2.
- WIDTH=8, nine rows of zeros except row 4 col 3 = 255: column-3 outputs for rows 4..8 are 5, 57, 127, 57, 5; every other output is 0.
- Constant 255 frame: every valid dout=255 (sum 65280, no wrap).
- Repeat the impulse test with random 0-3 idle cycles between pixels: results are identical, no validout on idle cycles, dout unchanged during gaps.
- sof asserted at row 2 col 5: counters restart there, and no validout is produced until the 4th line after that sof.
- reset driven low mid-row 5 with the clock stopped: dout=0 and validout=0 immediately; after release, four new rows are required before the first validout.
